// File: rtl/ysyx_20020207_ctrl_pkg.sv
// Shared types and constants for the ysyx_20020207 core sequencer.
// CORE_CTRL_IRQ_EN adds the TRAP state for timer-interrupt entry.
package ysyx_20020207_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
`ifdef CORE_CTRL_IRQ_EN
    S_TRAP,
`endif
    S_HALT
  } state_t;

  localparam logic [1:0] HALT_EBREAK = 2'd0;
  localparam logic [1:0] HALT_IFU    = 2'd1;
  localparam logic [1:0] HALT_LSU    = 2'd2;
  localparam logic [1:0] HALT_WDOG   = 2'd3;

  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/ysyx_20020207_core_ctrl_if.sv
// IFU/LSU request/done handshake bundle seen by the sequencer.
// master = sequencer side, slave = IFU/LSU side.
interface ysyx_20020207_core_ctrl_if;
  logic ifu_req;
  logic ifu_done;
  logic ifu_err;
  logic lsu_req;
  logic lsu_done;
  logic lsu_err;

  modport master (
    output ifu_req, lsu_req,
    input  ifu_done, ifu_err,
    input  lsu_done, lsu_err
  );

  modport slave (
    input  ifu_req, lsu_req,
    output ifu_done, ifu_err,
    output lsu_done, lsu_err
  );
endinterface

// File: rtl/ysyx_20020207_wdog.sv
// Bus watchdog: counts cycles spent in a wait state and flags expiry
// on the last permitted cycle (count == TIMEOUT_CYCLES-1).
module ysyx_20020207_wdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/ysyx_20020207_core_ctrl.sv
// Multi-cycle sequencer: FETCH/EXEC/MEM/WB, halt, counters, watchdog.
// CORE_CTRL_IRQ_EN enables timer-interrupt entry via the TRAP state.
module ysyx_20020207_core_ctrl
  import ysyx_20020207_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_interrupt,
  input  logic             irq_enable,
  ysyx_20020207_core_ctrl_if.master bus,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_ebreak,
  input  logic             dec_reg_wen,
  input  logic             dec_csr_wen,
  output logic             pc_wen,
  output logic             reg_wen,
  output logic             csr_wen,
  output logic             trap,
  output logic [31:0]      trap_cause,
  output logic             halt,
  output logic [1:0]       halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  state_t     state, next;
  logic [1:0] code_q, code_d;
  logic       wait_st;
  logic       expire;
  logic       irq;

  assign wait_st = is_wait(state);

  ysyx_20020207_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clock),
    .rst    (reset),
    .clr    (!wait_st),
    .en     (wait_st),
    .expire (expire)
  );

`ifdef CORE_CTRL_IRQ_EN
  assign irq = io_interrupt & irq_enable;
`else
  logic unused_irq;
  assign unused_irq = io_interrupt ^ irq_enable;
  assign irq = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      code_q <= HALT_EBREAK;
    end else begin
      state  <= next;
      code_q <= code_d;
    end
  end

  always_comb begin
    next        = state;
    code_d      = code_q;
    bus.ifu_req = 1'b0;
    bus.lsu_req = 1'b0;
    pc_wen      = 1'b0;
    reg_wen     = 1'b0;
    csr_wen     = 1'b0;
    trap        = 1'b0;
    trap_cause  = '0;
    halt        = 1'b0;
    case (state)
      S_IDLE: next = S_FETCH;
      S_FETCH: begin
        bus.ifu_req = 1'b1;
        // a done pulse on the expiry cycle still wins
        if (bus.ifu_done) begin
          if (bus.ifu_err) begin
            next   = S_HALT;
            code_d = HALT_IFU;
          end else begin
            next = S_EXEC;
          end
        end else if (expire) begin
          next   = S_HALT;
          code_d = HALT_WDOG;
        end
      end
      S_EXEC: begin
        if (dec_is_ebreak) begin
          next   = S_HALT;
          code_d = HALT_EBREAK;
        end else if (dec_is_load || dec_is_store) begin
          next = S_MEM;
        end else begin
          next = S_WB;
        end
      end
      S_MEM: begin
        bus.lsu_req = 1'b1;
        if (bus.lsu_done) begin
          if (bus.lsu_err) begin
            next   = S_HALT;
            code_d = HALT_LSU;
          end else begin
            next = S_WB;
          end
        end else if (expire) begin
          next   = S_HALT;
          code_d = HALT_WDOG;
        end
      end
      S_WB: begin
        pc_wen  = 1'b1;
        reg_wen = dec_reg_wen;
        csr_wen = dec_csr_wen;
`ifdef CORE_CTRL_IRQ_EN
        next = irq ? S_TRAP : S_FETCH;
`else
        next = irq ? S_HALT : S_FETCH;
`endif
      end
`ifdef CORE_CTRL_IRQ_EN
      S_TRAP: begin
        pc_wen     = 1'b1;
        trap       = 1'b1;
        trap_cause = MCAUSE_MTI;
        next       = S_FETCH;
      end
`endif
      S_HALT: halt = 1'b1;
      default: next = S_IDLE;
    endcase
  end

  assign halt_code = code_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state == S_WB) instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

endmodule
